// File: rtl/reram_access_arbiter.sv
// reram_access_arbiter: round-robin arbiter/sequencer sharing one ReRAM core between two requesters (req/we/adr/dat/sel in, ack/err/dat out per requester; EN/R_WB/DI/SEL/AD/DO/func_ack core side; busy_o/grant_o status)
module reram_access_arbiter #(
  parameter logic [31:0] ADDR_MATCH     = 32'h3000_000c,
  parameter logic [3:0]  SEL_MATCH      = 4'b0010,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] adr0_i,
  input  logic [31:0] adr1_i,
  input  logic [31:0] dat0_i,
  input  logic [31:0] dat1_i,
  input  logic [3:0]  sel0_i,
  input  logic [3:0]  sel1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [31:0] dat0_o,
  output logic [31:0] dat1_o,
  output logic        EN,
  output logic        R_WB,
  output logic [31:0] DI,
  output logic [3:0]  SEL,
  output logic [31:0] AD,
  input  logic [31:0] DO,
  input  logic        func_ack,
  output logic        busy_o,
  output logic        grant_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BUSY, S_RESP} state_t;
  state_t r_state, w_next;
  logic r_last, r_we;
  logic [31:0] r_adr, r_dat;
  logic [3:0] r_sel;
  logic [CW-1:0] r_cnt;
  logic w_win, w_fire, w_tmo, w_to_resp, w_fail;
  logic [31:0] w_rdat;
  assign w_win = (req0_i && req1_i) ? ~r_last : req1_i;
  assign w_fire = (r_state == S_IDLE) && (req0_i || req1_i);
  assign w_tmo = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (req0_i || req1_i) ? S_CHECK : S_IDLE;
      S_CHECK: w_next = (r_adr == ADDR_MATCH && r_sel == SEL_MATCH) ? S_BUSY : S_RESP;
      S_BUSY:  w_next = (func_ack || w_tmo) ? S_RESP : S_BUSY;
      default: w_next = S_IDLE;
    endcase
  end
  assign w_to_resp = (r_state != S_RESP) && (w_next == S_RESP);
  assign w_fail = !(r_state == S_BUSY && func_ack);
  assign w_rdat = w_fail ? 32'h0 : DO;
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_last  <= 1'b1;
      grant_o <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      EN      <= 1'b0;
      R_WB    <= 1'b0;
      DI      <= '0;
      SEL     <= '0;
      AD      <= '0;
      ack0_o  <= 1'b0;
      ack1_o  <= 1'b0;
      err0_o  <= 1'b0;
      err1_o  <= 1'b0;
      dat0_o  <= '0;
      dat1_o  <= '0;
      busy_o  <= 1'b0;
    end else begin
      if (w_fire) begin
        r_last  <= w_win;
        grant_o <= w_win;
        r_we    <= w_win ? we1_i : we0_i;
        r_adr   <= w_win ? adr1_i : adr0_i;
        r_dat   <= w_win ? dat1_i : dat0_i;
        r_sel   <= w_win ? sel1_i : sel0_i;
      end
      r_cnt  <= (r_state != S_BUSY) ? '0 : (r_cnt == CW'(TIMEOUT_CYCLES)) ? r_cnt : r_cnt + 1'b1;
      EN     <= w_next == S_BUSY;
      R_WB   <= (w_next == S_BUSY) && r_we;
      DI     <= (w_next == S_BUSY) ? r_dat : '0;
      SEL    <= (w_next == S_BUSY) ? r_sel : '0;
      AD     <= (w_next == S_BUSY) ? r_adr : '0;
      ack0_o <= w_to_resp && !w_fail && !grant_o;
      ack1_o <= w_to_resp && !w_fail && grant_o;
      err0_o <= w_to_resp && w_fail && !grant_o;
      err1_o <= w_to_resp && w_fail && grant_o;
      if (w_to_resp && !grant_o) dat0_o <= w_rdat;
      if (w_to_resp && grant_o) dat1_o <= w_rdat;
      busy_o <= w_next != S_IDLE;
    end
  end
endmodule

// File: tb/tb_reram_access_arbiter.sv
// tb_reram_access_arbiter: randomized scoreboard bench for reram_access_arbiter with a transaction-level core/arbitration model
module tb_reram_access_arbiter;
  localparam int TMO = 4;
  localparam logic [31:0] AM = 32'h3000_000c;
  localparam logic [3:0] SM = 4'b0010;
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          delay;
    logic [31:0] dout;
  } cmd_t;
  typedef struct {
    int          id;
    bit          err;
    logic [31:0] dat;
    int          t;
  } exp_t;
  logic clk = 0, rst_n = 1;
  logic req0, req1, we0, we1, func_ack;
  logic [31:0] adr0, adr1, dat0, dat1, DO;
  logic [3:0] sel0, sel1;
  logic ack0_o, ack1_o, err0_o, err1_o, EN, R_WB, busy_o, grant_o;
  logic [31:0] dat0_o, dat1_o, DI, AD;
  logic [3:0] SEL;
  int checks = 0, errors = 0;
  int cyc = 0;
  bit drv_on = 0, mon_on = 0;
  cmd_t q0[$], q1[$], core_q[$], en_q[$];
  exp_t sb[$];
  reram_access_arbiter #(.ADDR_MATCH(AM), .SEL_MATCH(SM), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .adr0_i(adr0), .adr1_i(adr1), .dat0_i(dat0), .dat1_i(dat1),
    .sel0_i(sel0), .sel1_i(sel1),
    .ack0_o(ack0_o), .ack1_o(ack1_o), .err0_o(err0_o), .err1_o(err1_o),
    .dat0_o(dat0_o), .dat1_o(dat1_o),
    .EN(EN), .R_WB(R_WB), .DI(DI), .SEL(SEL), .AD(AD), .DO(DO),
    .func_ack(func_ack), .busy_o(busy_o), .grant_o(grant_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic cmd_t mk(input logic we, input logic [31:0] adr, input logic [3:0] sel, input int delay, input logic [31:0] dout);
    cmd_t c;
    c.we = we;
    c.adr = adr;
    c.dat = $urandom;
    c.sel = sel;
    c.delay = delay;
    c.dout = dout;
    return c;
  endfunction
  function automatic cmd_t rnd();
    logic [31:0] a;
    logic [3:0] s;
    a = ($urandom_range(0, 5) == 0) ? $urandom : AM;
    s = ($urandom_range(0, 5) == 0) ? 4'($urandom) : SM;
    return mk(1'($urandom), a, s, $urandom_range(0, 6), $urandom);
  endfunction
  bit last, d_prev;
  int ccnt;
  cmd_t cur;
  always @(negedge clk) begin
    if (!drv_on) begin
      q0.delete(); q1.delete(); core_q.delete();
      last = 1; d_prev = 0; ccnt = 0;
      req0 = 0; req1 = 0; func_ack = 0; DO = 0;
      we0 = 0; we1 = 0; adr0 = 0; adr1 = 0; dat0 = 0; dat1 = 0; sel0 = 0; sel1 = 0;
    end else begin
      if ((ack0_o || err0_o) && q0.size() > 0) void'(q0.pop_front());
      if ((ack1_o || err1_o) && q1.size() > 0) void'(q1.pop_front());
      if (EN) begin
        if (!d_prev) begin
          if (core_q.size() > 0) cur = core_q.pop_front();
          ccnt = 0;
        end
        func_ack = (ccnt == cur.delay);
        DO = func_ack ? cur.dout : $urandom;
        ccnt++;
      end else begin
        func_ack = 1'($urandom_range(0, 1));
        DO = $urandom;
      end
      d_prev = EN;
      req0 = q0.size() > 0;
      req1 = q1.size() > 0;
      if (!busy_o && req0) begin we0 = q0[0].we; adr0 = q0[0].adr; dat0 = q0[0].dat; sel0 = q0[0].sel; end
      else begin we0 = 1'($urandom); adr0 = $urandom; dat0 = $urandom; sel0 = 4'($urandom); end
      if (!busy_o && req1) begin we1 = q1[0].we; adr1 = q1[0].adr; dat1 = q1[0].dat; sel1 = q1[0].sel; end
      else begin we1 = 1'($urandom); adr1 = $urandom; dat1 = $urandom; sel1 = 4'($urandom); end
      if (!busy_o && (req0 || req1)) begin
        exp_t e;
        cmd_t c;
        bit w, ok;
        w = (req0 && req1) ? !last : req1;
        last = w;
        c = w ? q1[0] : q0[0];
        ok = (c.adr == AM) && (c.sel == SM);
        e.id = int'(w);
        e.err = !ok || c.delay >= TMO;
        e.dat = e.err ? 32'h0 : c.dout;
        e.t = cyc + (!ok ? 2 : (c.delay >= TMO ? 2 + TMO : 3 + c.delay));
        sb.push_back(e);
        if (ok) begin
          core_q.push_back(c);
          en_q.push_back(c);
        end
      end
    end
  end
  bit m_prev;
  int mlen;
  cmd_t mcur;
  logic [31:0] last_dat[2];
  always @(negedge clk) begin
    if (!mon_on) begin
      sb.delete(); en_q.delete();
      m_prev = 0; mlen = 0;
      last_dat[0] = 0; last_dat[1] = 0;
    end else begin
      if (EN) begin
        if (!m_prev) begin
          if (en_q.size() == 0) chk("en_unexpected", 32'(EN), 0);
          else mcur = en_q.pop_front();
          mlen = 0;
        end
        chk("AD", AD, mcur.adr);
        chk("DI", DI, mcur.dat);
        chk("R_WB", 32'(R_WB), 32'(mcur.we));
        chk("SEL", 32'(SEL), 32'(mcur.sel));
        mlen++;
      end else if (m_prev) chk("en_len", mlen, (mcur.delay >= TMO) ? TMO : mcur.delay + 1);
      m_prev = EN;
      if (ack0_o || err0_o || ack1_o || err1_o) begin
        chk("pulse_onehot", $countones({ack0_o, err0_o, ack1_o, err1_o}), 1);
        if (sb.size() == 0) chk("pulse_unexpected", 32'({ack0_o, err0_o, ack1_o, err1_o}), 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("grant", 32'(grant_o), e.id);
          chk("ack", 32'(e.id ? ack1_o : ack0_o), 32'(!e.err));
          chk("err", 32'(e.id ? err1_o : err0_o), 32'(e.err));
          chk("dat", e.id ? dat1_o : dat0_o, e.dat);
          chk("dat_hold", e.id ? dat0_o : dat1_o, last_dat[e.id ^ 1]);
          chk("latency", cyc, e.t);
          last_dat[e.id] = e.dat;
        end
      end
    end
  end
  task automatic drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending q0=%0d q1=%0d sb=%0d", q0.size(), q1.size(), sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_EN", 32'(EN), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_R_WB", 32'(R_WB), 0);
    chk("rst_AD", AD, 0);
    chk("rst_DI", DI, 0);
    chk("rst_SEL", 32'(SEL), 0);
    chk("rst_pulses", 32'({ack0_o, ack1_o, err0_o, err1_o}), 0);
    chk("rst_dat0", dat0_o, 0);
    chk("rst_dat1", dat1_o, 0);
    rst_n = 1;
    drv_on = 1;
    mon_on = 1;
    repeat (2) @(posedge clk);
    #1;
    q0.push_back(mk(1'b1, AM, SM, 2, 32'hA5A5_1234));
    drain();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk(1'($urandom), AM, SM, 0, $urandom));
      q1.push_back(mk(1'($urandom), AM, SM, 0, $urandom));
    end
    drain();
    q1.push_back(mk(1'b1, 32'h3000_0008, SM, 0, $urandom));
    q1.push_back(mk(1'b0, AM, 4'b0001, 0, $urandom));
    drain();
    q0.push_back(mk(1'b1, AM, SM, TMO - 1, 32'hCAFE_F00D));
    q1.push_back(mk(1'b1, AM, SM, 20, $urandom));
    q0.push_back(mk(1'b0, AM, SM, 1, $urandom));
    drain();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) q0.push_back(rnd());
      else q1.push_back(rnd());
    end
    drain();
    q0.push_back(mk(1'b1, AM, SM, 50, $urandom));
    begin
      int n = 0;
      while (!EN && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    #2;
    chk("en_before_rst", 32'(EN), 1);
    mon_on = 0;
    drv_on = 0;
    rst_n = 0;
    #1;
    chk("arst_EN", 32'(EN), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_pulses", 32'({ack0_o, ack1_o, err0_o, err1_o}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    drv_on = 1;
    mon_on = 1;
    repeat (10) @(posedge clk);
    #1;
    q0.push_back(mk(1'b1, AM, SM, 0, $urandom));
    q1.push_back(mk(1'b0, AM, SM, 1, $urandom));
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/reram_access_arbiter.md
# reram_access_arbiter

Round-robin arbiter and sequencer that shares the single functional ReRAM core between two requesters, e.g. the Wishbone host path and a local compute engine. It accepts one command at a time, registers it, and drives the core's EN/R_WB/DI/SEL/AD inputs until the core returns func_ack. It then returns read data with a one-cycle ack to the winning requester. It also enforces the core's address/byte-select decode rule and flags a timeout if the core never answers.

## Interface
Parameters:
- ADDR_MATCH, 32'h3000_000c: the only address the core accepts.
- SEL_MATCH, 4'b0010: the only byte select the core accepts.
- TIMEOUT_CYCLES, 255: the maximum number of BUSY cycles without func_ack before an error (legal range 1..65535).

Ports:
- wb_clk_i, in, 1: the single clock for the block.
- wb_rst_i, in, 1: reset, asynchronous and active-low.
- req0_i / req1_i, in, 1: request from requester 0 / 1. Held high until the matching ack or err pulse.
- we0_i / we1_i, in, 1: direction; 1 = read, 0 = write.
- adr0_i / adr1_i, in, 32: command address.
- dat0_i / dat1_i, in, 32: write data.
- sel0_i / sel1_i, in, 4: byte select.
- ack0_o / ack1_o, out, 1: one-cycle completion pulse.
- err0_o / err1_o, out, 1: one-cycle error pulse (decode reject or timeout).
- dat0_o / dat1_o, out, 32: response data, valid during the ack or err pulse.
- EN, out, 1: core enable.
- R_WB, out, 1: core direction (1 = read).
- DI, out, 32: core write data.
- SEL, out, 4: core byte select.
- AD, out, 32: core address.
- DO, in, 32: core read data.
- func_ack, in, 1: core acknowledge.
- busy_o, out, 1: high in every state other than IDLE.
- grant_o, out, 1: index of the current or most recent winner.

## Operation
- FSM states: IDLE, CHECK, BUSY, RESP.
- IDLE:
  - If any req*_i is high, pick the winner and latch its we/adr/dat/sel into the command registers. Then go to CHECK.
  - Arbitration is round-robin. With both requesting, the winner is the index that is not equal to last_grant. With one requesting, that one wins.
  - last_grant is updated on every grant.
- CHECK:
  - If the latched adr == ADDR_MATCH and sel == SEL_MATCH, go to BUSY.
  - Otherwise go to RESP with the error flag set and response data 32'h0. EN is never asserted in this case.
- BUSY:
  - EN = 1. R_WB, DI, SEL and AD are driven from the latched command and held stable for the whole state.
  - The timeout counter increments each cycle.
  - func_ack high: capture DO into the response register and go to RESP with the error flag clear.
  - Counter reaches TIMEOUT_CYCLES without func_ack: go to RESP with the error flag set and response data 32'h0.
  - If func_ack and timeout expiry occur in the same cycle, func_ack wins.
- RESP:
  - Pulse ack or err for exactly one cycle, only to the granted requester. Drive the response register on its dat*_o.
  - Clear the counter and go to IDLE.
- Other rules:
  - func_ack outside BUSY is ignored.
  - The command is sampled only in IDLE. Changes to a requester's inputs while it is granted have no effect.
  - A requester still high in the IDLE cycle after its pulse is treated as a new request.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter does not wrap; it saturates until the FSM leaves BUSY.

## Timing
- All outputs are registered.
- Reset values (on an asynchronous assert, including mid-transaction):
  - state = IDLE.
  - EN, R_WB, ack*, err*, busy_o = 0.
  - DI, SEL, AD, dat*_o = 0.
  - grant_o = 0, last_grant = 1, so requester 0 wins the first tie.
  - An aborted transaction produces no ack or err.
- Normal flow, request first seen in IDLE at cycle t:
  - CHECK at t+1.
  - EN rises at t+2.
  - func_ack first high at cycle k ≥ t+2 means EN falls at k+1, and ack/dat are valid at k+1.
  - Minimum request-to-ack latency is 3 cycles. Back-to-back grant spacing is at least 4 cycles.
- Decode reject: err pulse at t+2; EN stays 0.
- Timeout: EN is high for exactly TIMEOUT_CYCLES cycles, then err is high in the following cycle.
- dat*_o for a requester holds its last value until that requester's next response.

## Test plan
- Single read, requester 0: adr 32'h3000_000c, sel 4'b0010, we 1. The core returns DO = 32'hA5A5_1234 with func_ack 2 cycles after EN rises. Expect EN high for 3 cycles, ack0_o for 1 cycle with dat0_o = 32'hA5A5_1234, and ack1_o/err* never asserted.
- Both requesters high continuously for 4 transactions, core ack immediate. Expect the grant order 0,1,0,1, and AD/DI/R_WB matching each winner's latched command for its whole EN window.
- Requester 1 with adr 32'h3000_0008 (or sel 4'b0001). Expect EN never asserted, err1_o pulses exactly 2 cycles after the request with dat1_o = 0.
- TIMEOUT_CYCLES = 4, core never acks. Expect EN high for exactly 4 cycles, then err pulse. A func_ack arriving after that is ignored, and the next request is served normally.
- func_ack on exactly the final timeout cycle. Expect an ack, not an err, with the captured DO.
- Assert wb_rst_i low while in BUSY. Expect EN, busy_o, ack* and err* to go to 0 immediately (asynchronously), with no pulse after release. The first request after reset is granted to requester 0 when both request.
